imem_loader: RTL

- Boot-time writer for the instruction memory that the fetch stage reads.
- Accepts a framed byte stream with valid/ready handshake: 16-bit word count, little-endian instruction words, XOR checksum.
- Assembles 32-bit words and writes them sequentially from BASE_ADDR.
- Raises done on a good load so the bench or top level can release the CPU with PC = pc_entry; raises err on a bad frame.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_word_packer.sv | 36 +++
 rtl/imem_loader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Holds the loader state encoding, default parameters and framing constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_0028;
    localparam int unsigned MAX_WORDS_DEF = 1024;

    // Frame: count[7:0], count[15:8], then each word LSB first, then XOR checksum.
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam logic [1:0]  LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles little-endian bytes into 32-bit words and flags the byte that
// completes a word, so the loader can write it on the following cycle.
module imem_loader_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    logic [1:0]  byte_idx_q;
    logic [23:0] data_q;

    // The completing byte bypasses the register so the word is whole on the accepting edge.
    assign word_ready_o = byte_valid_i && (byte_idx_q == LAST_BYTE_IDX);
    assign word_o       = {byte_i, data_q};

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_q <= '0;
            data_q     <= '0;
        end else if (clear_i) begin
            byte_idx_q <= '0;
            data_q     <= '0;
        end else if (byte_valid_i) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            data_q     <= {byte_i, data_q[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: parses a counted, checksummed byte
// frame and writes the assembled words sequentially from BASE_ADDR.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int unsigned MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded,
    output logic [31:0] pc_entry
);

    state_e      state_q;
    logic [15:0] count_q;
    logic [15:0] word_idx_q;
    logic [15:0] words_loaded_q;
    logic [7:0]  csum_q;
    logic        done_q;
    logic        err_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic        accept;
    logic        restart;
    logic        word_ready;
    logic [31:0] word;
    logic [15:0] count_d;
    logic [7:0]  csum_d;

    assign in_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                      (state_q == ST_DATA)   || (state_q == ST_CSUM);
    assign busy     = in_ready;
    assign accept   = in_valid && in_ready;
    assign restart  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                (state_q == ST_ERR));
    assign count_d  = {in_data, count_q[7:0]};
    assign csum_d   = csum_q ^ in_data;

    imem_loader_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (restart),
        .byte_valid_i (accept && (state_q == ST_DATA)),
        .byte_i       (in_data),
        .word_o       (word),
        .word_ready_o (word_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            word_idx_q     <= '0;
            words_loaded_q <= '0;
            csum_q         <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if (restart) begin
                state_q        <= ST_LEN_LO;
                count_q        <= '0;
                word_idx_q     <= '0;
                words_loaded_q <= '0;
                csum_q         <= '0;
                done_q         <= 1'b0;
                err_q          <= 1'b0;
            end else if (accept) begin
                case (state_q)
                    ST_LEN_LO: begin
                        count_q[7:0] <= in_data;
                        csum_q       <= csum_d;
                        state_q      <= ST_LEN_HI;
                    end
                    ST_LEN_HI: begin
                        count_q <= count_d;
                        csum_q  <= csum_d;
                        if (32'(count_d) > MAX_WORDS) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else if (count_d == 16'd0) begin
                            state_q <= ST_CSUM;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        csum_q <= csum_d;
                        if (word_ready) begin
                            // Address and data stay registered until the next word overwrites them.
                            mem_we_q       <= 1'b1;
                            mem_addr_q     <= BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                            mem_wdata_q    <= word;
                            word_idx_q     <= word_idx_q + 16'd1;
                            words_loaded_q <= words_loaded_q + 16'd1;
                            if (word_idx_q == count_q - 16'd1) begin
                                state_q <= ST_CSUM;
                            end
                        end
                    end
                    ST_CSUM: begin
                        if (in_data == csum_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_loaded_q;
    assign pc_entry     = BASE_ADDR;

endmodule
